// File: rtl/complex_mac_lanes_if.sv
// Bus bundle for complex_mac_lanes: input beat handshake, output handshake,
// flush and status. The DUT uses the slave view, the driver the master view.
interface complex_mac_lanes_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ACC_W  = 40
);
  logic [LANES*2*DATA_W-1:0] a_i;
  logic [LANES*2*DATA_W-1:0] b_i;
  logic [1:0]                mode_i;
  logic                      acc_clr_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic                      flush_i;
  logic [LANES*2*ACC_W-1:0]  result_o;
  logic [LANES-1:0]          ovf_o;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic                      busy_o;

  modport master (
    output a_i, b_i, mode_i, acc_clr_i, in_valid_i, flush_i, out_ready_i,
    input  in_ready_o, result_o, ovf_o, out_valid_o, busy_o
  );

  modport slave (
    input  a_i, b_i, mode_i, acc_clr_i, in_valid_i, flush_i, out_ready_i,
    output in_ready_o, result_o, ovf_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/complex_mac_lanes.sv
// Multi-lane complex multiply / multiply-accumulate with a two-stage pipeline.
// Stage 1 registers the four partial products per lane, stage 2 combines them,
// optionally conjugates B, and accumulates with per-component saturation.
module complex_mac_lanes #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ACC_W  = 40
) (
  input logic             clk_i,
  input logic             rst_i,
  complex_mac_lanes_if.slave bus
);

  localparam int unsigned PW = 2 * DATA_W;   // full-precision product width
  localparam int unsigned BW = 2 * DATA_W;   // operand bits per lane {im,re}
  localparam int unsigned RW = 2 * ACC_W;    // result bits per lane {im,re}
  localparam int unsigned SW = ACC_W + 1;    // accumulate width before saturation

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // The product sum must fit the accumulator without wrapping.
  if (ACC_W < 2 * DATA_W + 1) begin : g_acc_w_check
    $error("complex_mac_lanes: ACC_W must be at least 2*DATA_W+1");
  end

  logic en;
  logic accept;
  logic s1_valid;
  logic s2_valid;
  logic [1:0] s1_mode;
  logic       s1_clr;

  logic signed [PW-1:0] p_rr [LANES];
  logic signed [PW-1:0] p_ii [LANES];
  logic signed [PW-1:0] p_ir [LANES];
  logic signed [PW-1:0] p_ri [LANES];

  logic signed [PW-1:0] s1_rr [LANES];
  logic signed [PW-1:0] s1_ii [LANES];
  logic signed [PW-1:0] s1_ir [LANES];
  logic signed [PW-1:0] s1_ri [LANES];

  logic signed [ACC_W-1:0] acc_re [LANES];
  logic signed [ACC_W-1:0] acc_im [LANES];

  logic signed [ACC_W-1:0] prod_re [LANES];
  logic signed [ACC_W-1:0] prod_im [LANES];
  logic signed [ACC_W-1:0] base_re [LANES];
  logic signed [ACC_W-1:0] base_im [LANES];
  logic signed [SW-1:0]    sum_re  [LANES];
  logic signed [SW-1:0]    sum_im  [LANES];
  logic signed [ACC_W-1:0] nxt_re  [LANES];
  logic signed [ACC_W-1:0] nxt_im  [LANES];
  logic [LANES-1:0]        sat_re;
  logic [LANES-1:0]        sat_im;
  logic [LANES-1:0]        nxt_ovf;

  logic [LANES*RW-1:0] result_q;
  logic [LANES-1:0]    ovf_q;

  // Whole pipeline advances unless the output beat is being held back.
  assign en             = !(s2_valid && !bus.out_ready_i);
  assign bus.in_ready_o = en && !bus.flush_i && !rst_i;
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  assign bus.out_valid_o = s2_valid;
  assign bus.result_o    = result_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.busy_o      = s1_valid || s2_valid;

  // Full-precision partial products of the incoming beat.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      p_rr[l] = PW'($signed(bus.a_i[l*BW +: DATA_W]))
              * PW'($signed(bus.b_i[l*BW +: DATA_W]));
      p_ii[l] = PW'($signed(bus.a_i[l*BW+DATA_W +: DATA_W]))
              * PW'($signed(bus.b_i[l*BW+DATA_W +: DATA_W]));
      p_ir[l] = PW'($signed(bus.a_i[l*BW+DATA_W +: DATA_W]))
              * PW'($signed(bus.b_i[l*BW +: DATA_W]));
      p_ri[l] = PW'($signed(bus.a_i[l*BW +: DATA_W]))
              * PW'($signed(bus.b_i[l*BW+DATA_W +: DATA_W]));
    end
  end

  // Stage 1: capture products, mode and clear flag of an accepted beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_mode  <= 2'd0;
      s1_clr   <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        s1_rr[l] <= '0;
        s1_ii[l] <= '0;
        s1_ir[l] <= '0;
        s1_ri[l] <= '0;
      end
    end else if (bus.flush_i) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_mode <= bus.mode_i;
        s1_clr  <= bus.acc_clr_i;
        for (int unsigned l = 0; l < LANES; l++) begin
          s1_rr[l] <= p_rr[l];
          s1_ii[l] <= p_ii[l];
          s1_ir[l] <= p_ir[l];
          s1_ri[l] <= p_ri[l];
        end
      end
    end
  end

  // Stage 2 datapath: combine products, accumulate, saturate, sticky overflow.
  // mode[0] selects accumulate, mode[1] selects conjugated B.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      prod_re[l] = s1_mode[1] ? ACC_W'(s1_rr[l]) + ACC_W'(s1_ii[l])
                              : ACC_W'(s1_rr[l]) - ACC_W'(s1_ii[l]);
      prod_im[l] = s1_mode[1] ? ACC_W'(s1_ir[l]) - ACC_W'(s1_ri[l])
                              : ACC_W'(s1_ir[l]) + ACC_W'(s1_ri[l]);
      base_re[l] = s1_clr ? '0 : acc_re[l];
      base_im[l] = s1_clr ? '0 : acc_im[l];
      sum_re[l]  = SW'(base_re[l]) + SW'(prod_re[l]);
      sum_im[l]  = SW'(base_im[l]) + SW'(prod_im[l]);
      sat_re[l]  = sum_re[l][SW-1] != sum_re[l][SW-2];
      sat_im[l]  = sum_im[l][SW-1] != sum_im[l][SW-2];
      if (s1_mode[0]) begin
        nxt_re[l]  = sat_re[l] ? (sum_re[l][SW-1] ? ACC_MIN : ACC_MAX)
                               : sum_re[l][ACC_W-1:0];
        nxt_im[l]  = sat_im[l] ? (sum_im[l][SW-1] ? ACC_MIN : ACC_MAX)
                               : sum_im[l][ACC_W-1:0];
        nxt_ovf[l] = (ovf_q[l] && !s1_clr) || sat_re[l] || sat_im[l];
      end else begin
        nxt_re[l]  = prod_re[l];
        nxt_im[l]  = prod_im[l];
        nxt_ovf[l] = 1'b0;
      end
    end
  end

  // Stage 2: output register, accumulators and overflow flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      result_q <= '0;
      ovf_q    <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        acc_re[l] <= '0;
        acc_im[l] <= '0;
      end
    end else if (bus.flush_i) begin
      s2_valid <= 1'b0;
      ovf_q    <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        acc_re[l] <= '0;
        acc_im[l] <= '0;
      end
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        ovf_q <= nxt_ovf;
        for (int unsigned l = 0; l < LANES; l++) begin
          acc_re[l]                       <= nxt_re[l];
          acc_im[l]                       <= nxt_im[l];
          result_q[l*RW +: ACC_W]         <= nxt_re[l];
          result_q[l*RW+ACC_W +: ACC_W]   <= nxt_im[l];
        end
      end
    end
  end

endmodule

// File: doc/complex_mac_lanes.md
COMPLEX_MAC_LANES -- requirements
Module: complex_mac_lanes

Interface
REQ-001 Parameter DATA_W, default 16: signed two's-complement width of each real/imag operand component.
REQ-002 Parameter LANES, default 2: number of independent complex lanes processed per beat.
REQ-003 Parameter ACC_W, default 40: signed width of each accumulator/result component; elaboration SHALL fail if ACC_W < 2*DATA_W+1.
REQ-004 clk_i  in  1  single clock; all state rising-edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 a_i  in  LANES*2*DATA_W  operand A per lane, {im,re} per lane, lane 0 in LSBs.
REQ-007 b_i  in  LANES*2*DATA_W  operand B per lane, same packing.
REQ-008 mode_i  in  2  0=MUL, 1=MAC, 2=MUL_CONJ (A*conj(B)), 3=MAC_CONJ; sampled with the beat.
REQ-009 acc_clr_i  in  1  beat starts from a zero accumulator (MAC modes); sampled with the beat.
REQ-010 in_valid_i / in_ready_o  in/out  1/1  input handshake; beat accepted when both high.
REQ-011 flush_i  in  1  synchronous pipeline flush.
REQ-012 result_o  out  LANES*2*ACC_W  {im,re} per lane, lane 0 in LSBs.
REQ-013 ovf_o  out  LANES  per-lane sticky saturation flag.
REQ-014 out_valid_o / out_ready_i  out/in  1/1  output handshake.
REQ-015 busy_o  out  1  high while any pipeline stage holds a valid beat.

Function
REQ-016 Stage 1 SHALL register the four full-precision 2*DATA_W products per lane (ar*br, ai*bi, ai*br, ar*bi) plus mode and acc_clr.
REQ-017 Stage 2 SHALL form re=ar*br-ai*bi, im=ai*br+ar*bi (non-conj) or re=ar*br+ai*bi, im=ai*br-ar*bi (conj), sign-extended to ACC_W, and register the result.
REQ-018 MUL modes: result = product; the accumulator SHALL be loaded with the product.
REQ-019 MAC modes: result = acc + product (acc taken as 0 when acc_clr set); the accumulator SHALL be updated with the result.
REQ-020 Latency SHALL be exactly 2 cycles from acceptance to out_valid_o with no backpressure; throughput one beat/cycle.
REQ-021 Stall: pipeline enable en = !(out_valid_o && !out_ready_i); in_ready_o = en && !flush_i; stage registers and accumulator SHALL hold when en is low.
REQ-022 result_o SHALL be stable while out_valid_o && !out_ready_i.
REQ-023 MAC addition SHALL saturate per component to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; on saturation ovf_o[lane] SHALL set.
REQ-024 ovf_o[lane] SHALL clear only on reset, flush, or a beat reaching stage 2 with acc_clr set or in a MUL mode (which then sets it only if that beat saturates).
REQ-025 flush_i SHALL clear both stage valids, accumulators and ovf_o next edge; a beat presented with flush_i high is not accepted.
REQ-026 Simultaneous output handshake and new input acceptance in the same cycle SHALL be permitted (no bubble).
REQ-027 Lanes SHALL be fully independent; one lane saturating does not affect others.
REQ-028 busy_o = stage1_valid || stage2_valid.

Reset
REQ-029 While rst_i high: in_ready_o=0; out_valid_o=0, result_o=0, ovf_o=0, busy_o=0, accumulators=0, stage valids=0.
REQ-030 Reset assertion mid-operation SHALL discard in-flight beats immediately; first cycle after deassertion in_ready_o=1.

Verification
REQ-031 MUL, lane0 A=3+4j, B=1+2j, out_ready_i=1 -> 2 cycles later result re=-5, im=10, ovf_o=0.
REQ-032 MUL_CONJ, A=3+4j, B=1+2j -> re=11, im=-2.
REQ-033 MAC, 4 back-to-back beats A=B=1+1j, first with acc_clr -> outputs 2j, 4j, 6j, 8j on consecutive cycles.
REQ-034 ACC_W=33, DATA_W=16, MAC, A=-32768-32768j, B=-32768+32768j twice (acc_clr first) -> re 2^31 then saturates to 2^32-1, ovf_o[0]=1, stays 1 until an acc_clr beat.
REQ-035 out_ready_i low 5 cycles with continuous in_valid_i -> in_ready_o low after the pipeline fills, no beat lost/duplicated, order preserved, result_o stable.
REQ-036 rst_i pulse (and separately flush_i) with two beats in flight -> neither output, busy_o=0, next MAC beat without acc_clr starts from accumulator 0.
